// File: rtl/ldpc_codeword_loader_pkg.sv
// ldpc_codeword_loader_pkg: shared bank/FSM encodings and codeword-length table for the ldpcFramer family
package ldpc_codeword_loader_pkg;

  localparam logic [1:0] LDPC_RATE_1_2 = 2'd0;
  localparam logic [1:0] LDPC_RATE_2_3 = 2'd1;
  localparam logic [1:0] LDPC_RATE_4_5 = 2'd2;

  typedef enum logic [1:0] {
    BANK_FREE = 2'b00,
    BANK_FULL = 2'b01,
    BANK_BUSY = 2'b11
  } bank_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DROP = 2'd2
  } fill_state_t;

  // 64-bit words per codeword; the k=4096 lengths are exactly four times the k=1024 ones
  function automatic logic [7:0] cw_words(input logic [1:0] rate, input logic long_k);
    logic [7:0] w;
    w = rate == LDPC_RATE_2_3 ? 8'd24 : rate == LDPC_RATE_4_5 ? 8'd20 : 8'd32;
    return long_k ? {w[5:0], 2'b00} : w;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return &v ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ldpc_word_packer.sv
// ldpc_word_packer: MSB-first 64-bit serial-to-parallel assembler with a word-complete strobe
module ldpc_word_packer (
  input  logic        clk,
  input  logic        resetN,
  input  logic        clr,
  input  logic        shift,
  input  logic        bit_in,
  output logic        word_ready,
  output logic [63:0] word_next
);

  logic [63:0] sr_q, sr_d;
  logic [5:0]  cnt_q, cnt_d;

  assign word_next  = {sr_q[62:0], bit_in};
  assign word_ready = shift && &cnt_q;

  // shift in a bit or clear the bit count when no codeword is being assembled
  always_comb begin
    sr_d  = shift ? word_next : sr_q;
    cnt_d = shift ? cnt_q + 6'd1 : clr ? 6'd0 : cnt_q;
  end

  // assembly register and bit count
  always_ff @(posedge clk) begin
    if (!resetN) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ldpc_codeword_loader.sv
// ldpc_codeword_loader: fills a two-bank codeword buffer from the framer bit stream and hands banks to the decoder
module ldpc_codeword_loader
  import ldpc_codeword_loader_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        clkEn,
  input  logic        ldpcRun,
  input  logic        codeLength4096,
  input  logic [1:0]  codeRate,
  input  logic        dataBitIn,
  input  logic        codewordEn,
  output logic        ldpcReady,
  output logic        wrEn,
  output logic [7:0]  wrAddr,
  output logic [63:0] wrData,
  output logic        cwValid,
  output logic        cwBank,
  output logic [7:0]  cwWords,
  input  logic        cwTake,
  input  logic        decDone,
  input  logic        doneBank,
  output logic [7:0]  overflowCount,
  output logic [7:0]  abortCount,
  output logic [3:0]  bankState
);

  fill_state_t     state_q, state_d;
  logic            ce_prev_q, ce_prev_d;
  logic            fill_bank_q, fill_bank_d;
  logic [6:0]      word_idx_q, word_idx_d;
  logic [1:0][7:0] len_q, len_d;
  logic [1:0][1:0] bank_q, bank_d;
  logic            oldest_q, oldest_d;
  logic            wr_en_q, wr_en_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
  logic [63:0]     wr_data_q, wr_data_d;
  logic            ready_q, ready_d;
  logic [7:0]      ovf_q, ovf_d;
  logic [7:0]      abt_q, abt_d;

  logic        rise, has_free, sel, shift, last, complete, take, cw_bank, word_ready;
  logic [63:0] word_next;

  assign rise     = clkEn && codewordEn && !ce_prev_q;
  assign has_free = bank_q[0] == BANK_FREE || bank_q[1] == BANK_FREE;
  assign sel      = bank_q[0] != BANK_FREE;
  assign shift    = ldpcRun && state_q != ST_DROP && clkEn && codewordEn
                    && (state_q == ST_FILL || (state_q == ST_IDLE && !ce_prev_q && has_free));
  assign last     = {1'b0, word_idx_q} == len_q[fill_bank_q] - 8'd1;
  assign complete = word_ready && state_q == ST_FILL && last;
  assign cwValid  = bank_q[0] == BANK_FULL || bank_q[1] == BANK_FULL;
  assign cw_bank  = bank_q[0] == BANK_FULL && bank_q[1] == BANK_FULL ? oldest_q : bank_q[1] == BANK_FULL;
  assign take     = cwTake && cwValid;

  assign ldpcReady     = ready_q;
  assign wrEn          = wr_en_q;
  assign wrAddr        = wr_addr_q;
  assign wrData        = wr_data_q;
  assign cwBank        = cw_bank;
  assign cwWords       = len_q[cw_bank];
  assign overflowCount = ovf_q;
  assign abortCount    = abt_q;
  assign bankState     = {bank_q[1], bank_q[0]};

  ldpc_word_packer u_packer (
    .clk        (clk),
    .resetN     (resetN),
    .clr        (state_d != ST_FILL),
    .shift      (shift),
    .bit_in     (dataBitIn),
    .word_ready (word_ready),
    .word_next  (word_next)
  );

  // fill FSM, word writes, bank lifecycle, completion order and status counters
  always_comb begin
    state_d     = state_q;
    ce_prev_d   = clkEn ? codewordEn : ce_prev_q;
    fill_bank_d = fill_bank_q;
    word_idx_d  = word_idx_q;
    len_d       = len_q;
    bank_d      = bank_q;
    oldest_d    = oldest_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    ovf_d       = ovf_q;
    abt_d       = abt_q;
    case (state_q)
      ST_IDLE: if (rise && has_free) begin
        state_d      = ST_FILL;
        fill_bank_d  = sel;
        word_idx_d   = '0;
        len_d[sel]   = cw_words(codeRate, codeLength4096);
      end else if (rise) begin
        state_d = ST_DROP;
        ovf_d   = sat_inc(ovf_q);
      end
      ST_FILL: if (clkEn && !codewordEn) begin
        state_d = ST_IDLE;
        abt_d   = sat_inc(abt_q);
      end
      ST_DROP: if (clkEn && !codewordEn) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (word_ready && state_q == ST_FILL) begin
      wr_en_d    = 1'b1;
      wr_addr_d  = {fill_bank_q, word_idx_q};
      wr_data_d  = word_next;
      word_idx_d = word_idx_q + 7'd1;
      state_d    = last ? ST_IDLE : ST_FILL;
    end
    for (int b = 0; b < 2; b++) begin
      bank_d[b] = bank_q[b] == 2'b10 ? BANK_FREE : bank_q[b];
      if (take && cw_bank == b[0] && bank_q[b] == BANK_FULL) bank_d[b] = BANK_BUSY;
      if (decDone && doneBank == b[0] && bank_q[b] == BANK_BUSY) bank_d[b] = BANK_FREE;
    end
    if (complete) begin
      bank_d[fill_bank_q] = BANK_FULL;
      oldest_d            = bank_d[~fill_bank_q] == BANK_FULL ? ~fill_bank_q : fill_bank_q;
    end
    if (!ldpcRun) begin
      state_d   = ST_IDLE;
      ce_prev_d = 1'b1;
      bank_d    = '0;
      oldest_d  = 1'b0;
      wr_en_d   = 1'b0;
      ovf_d     = ovf_q;
      abt_d     = abt_q;
    end
    ready_d = (bank_d[0] == BANK_FREE && !(state_d == ST_FILL && !fill_bank_d))
           || (bank_d[1] == BANK_FREE && !(state_d == ST_FILL && fill_bank_d));
  end

  // state registers; ce_prev resets high so a window already open at reset is not taken as a new codeword
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      ce_prev_q   <= 1'b1;
      fill_bank_q <= 1'b0;
      word_idx_q  <= '0;
      len_q       <= {8'd32, 8'd32};
      bank_q      <= '0;
      oldest_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      ready_q     <= 1'b1;
      ovf_q       <= '0;
      abt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ce_prev_q   <= ce_prev_d;
      fill_bank_q <= fill_bank_d;
      word_idx_q  <= word_idx_d;
      len_q       <= len_d;
      bank_q      <= bank_d;
      oldest_q    <= oldest_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      ready_q     <= ready_d;
      ovf_q       <= ovf_d;
      abt_q       <= abt_d;
    end
  end

endmodule

// File: tb/tb_ldpc_codeword_loader.sv
// tb_ldpc_codeword_loader: scoreboard bench for the two-bank codeword loader
module tb_ldpc_codeword_loader;
  import ldpc_codeword_loader_pkg::*;

  logic        clk = 1'b0;
  logic        resetN, clkEn, ldpcRun, codeLength4096, dataBitIn, codewordEn;
  logic [1:0]  codeRate;
  logic        ldpcReady, wrEn, cwValid, cwBank, cwTake, decDone, doneBank;
  logic [7:0]  wrAddr, cwWords, overflowCount, abortCount;
  logic [63:0] wrData;
  logic [3:0]  bankState;

  typedef struct packed {
    logic [7:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  logic        use_pat = 1'b0;
  logic [63:0] pat_word = 64'hFCB88938D8D76A4F;

  always #5 clk = ~clk;

  ldpc_codeword_loader dut (
    .clk(clk), .resetN(resetN), .clkEn(clkEn), .ldpcRun(ldpcRun),
    .codeLength4096(codeLength4096), .codeRate(codeRate),
    .dataBitIn(dataBitIn), .codewordEn(codewordEn), .ldpcReady(ldpcReady),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .cwValid(cwValid), .cwBank(cwBank), .cwWords(cwWords),
    .cwTake(cwTake), .decDone(decDone), .doneBank(doneBank),
    .overflowCount(overflowCount), .abortCount(abortCount), .bankState(bankState)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wrEn === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("wr_unexpected", {56'd0, wrAddr}, 64'hFFFF);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {56'd0, wrAddr}, {56'd0, e.addr});
        chk("wr_data", wrData, e.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int nbits, input bit acc, input bit bank, input bit gaps, input bit hold);
    logic [63:0] w;
    logic        b;
    w = '0;
    for (int i = 0; i < nbits; i++) begin
      codewordEn = 1'b1;
      if (gaps && $urandom_range(3) == 0) begin
        clkEn     = 1'b0;
        dataBitIn = 1'($urandom_range(1));
        tick(1);
      end
      clkEn     = 1'b1;
      b         = (use_pat && i < 64) ? pat_word[63-i] : 1'($urandom_range(1));
      dataBitIn = b;
      w         = {w[62:0], b};
      if (acc && i % 64 == 63) exp_q.push_back(wr_t'{{bank, 7'(i / 64)}, w});
      tick(1);
    end
    if (!hold) begin
      codewordEn = 1'b0;
      dataBitIn  = 1'b0;
      tick(4);
    end
  endtask

  task automatic pulse(input bit take, input bit done, input bit dbank);
    cwTake   = take;
    decDone  = done;
    doneBank = dbank;
    tick(1);
    cwTake  = 1'b0;
    decDone = 1'b0;
    tick(1);
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_wrEn"}, {63'd0, wrEn}, 64'd0);
    chk({pfx, "_cwValid"}, {63'd0, cwValid}, 64'd0);
    chk({pfx, "_cwBank"}, {63'd0, cwBank}, 64'd0);
    chk({pfx, "_wrAddr"}, {56'd0, wrAddr}, 64'd0);
    chk({pfx, "_wrData"}, wrData, 64'd0);
    chk({pfx, "_cwWords"}, {56'd0, cwWords}, 64'd32);
    chk({pfx, "_ready"}, {63'd0, ldpcReady}, 64'd1);
    chk({pfx, "_ovf"}, {56'd0, overflowCount}, 64'd0);
    chk({pfx, "_abt"}, {56'd0, abortCount}, 64'd0);
    chk({pfx, "_banks"}, {60'd0, bankState}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    resetN = 1'b0; clkEn = 1'b1; ldpcRun = 1'b1; codeLength4096 = 1'b0;
    codeRate = LDPC_RATE_1_2; dataBitIn = 1'b0; codewordEn = 1'b0;
    cwTake = 1'b0; decDone = 1'b0; doneBank = 1'b0;
    tick(3);
    chk_reset_state("rst");
    resetN = 1'b1;
    tick(3);

    // rate 1/2 k=1024, first word is the fixed pattern
    use_pat = 1'b1;
    send(2048, 1'b1, 1'b0, 1'b0, 1'b0);
    use_pat = 1'b0;
    chk("s1_wr_cnt", 64'(wr_cnt), 64'd32);
    chk("s1_cwValid", {63'd0, cwValid}, 64'd1);
    chk("s1_cwBank", {63'd0, cwBank}, 64'd0);
    chk("s1_cwWords", {56'd0, cwWords}, 64'd32);
    chk("s1_banks", {60'd0, bankState}, 64'b0001);
    chk("s1_ready", {63'd0, ldpcReady}, 64'd1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("s1_take", {60'd0, bankState}, 64'b0011);
    pulse(1'b0, 1'b1, 1'b0);
    chk("s1_done", {60'd0, bankState}, 64'b0000);
    pulse(1'b1, 1'b1, 1'b1);
    chk("s1_ignored", {60'd0, bankState}, 64'b0000);

    // rate 4/5 k=1024 back to back, then an overflow codeword
    codeRate = LDPC_RATE_4_5;
    send(1280, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("s2_cwWords", {56'd0, cwWords}, 64'd20);
    send(1280, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("s2_banks", {60'd0, bankState}, 64'b0101);
    chk("s2_ready", {63'd0, ldpcReady}, 64'd0);
    w0 = wr_cnt;
    send(1280, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s2_no_wr", 64'(wr_cnt), 64'(w0));
    chk("s2_ovf", {56'd0, overflowCount}, 64'd1);
    chk("s2_banks2", {60'd0, bankState}, 64'b0101);
    chk("s2_cwBank", {63'd0, cwBank}, 64'd0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("s2_take0", {60'd0, bankState}, 64'b0111);
    chk("s2_cwBank1", {63'd0, cwBank}, 64'd1);
    pulse(1'b0, 1'b1, 1'b0);
    chk("s2_done0", {60'd0, bankState}, 64'b0100);
    chk("s2_ready1", {63'd0, ldpcReady}, 64'd1);
    codeRate = LDPC_RATE_1_2;
    send(2048, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s2_oldest", {63'd0, cwBank}, 64'd1);
    chk("s2_old_words", {56'd0, cwWords}, 64'd20);
    pulse(1'b1, 1'b0, 1'b0);
    chk("s2_take1", {60'd0, bankState}, 64'b1101);
    chk("s2_cwBank0", {63'd0, cwBank}, 64'd0);
    chk("s2_words0", {56'd0, cwWords}, 64'd32);

    // cwTake bank 0 together with decDone bank 1
    pulse(1'b1, 1'b1, 1'b1);
    chk("s3_same_cycle", {60'd0, bankState}, 64'b0011);
    pulse(1'b0, 1'b1, 1'b0);
    chk("s3_free", {60'd0, bankState}, 64'b0000);

    // ldpcRun low clears banks but keeps counters
    codeRate = LDPC_RATE_4_5;
    send(1280, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s4_full", {60'd0, bankState}, 64'b0001);
    ldpcRun = 1'b0;
    tick(1);
    ldpcRun = 1'b1;
    chk("s4_banks", {60'd0, bankState}, 64'b0000);
    chk("s4_cwValid", {63'd0, cwValid}, 64'd0);
    chk("s4_ovf_kept", {56'd0, overflowCount}, 64'd1);
    tick(2);

    // abort after 100 bits
    codeRate = LDPC_RATE_1_2;
    w0 = wr_cnt;
    send(100, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s5_one_wr", 64'(wr_cnt), 64'(w0 + 1));
    chk("s5_abt", {56'd0, abortCount}, 64'd1);
    chk("s5_banks", {60'd0, bankState}, 64'b0000);
    chk("s5_cwValid", {63'd0, cwValid}, 64'd0);

    // reset mid word 10 of a k=4096 rate 2/3 fill
    codeRate = LDPC_RATE_2_3;
    codeLength4096 = 1'b1;
    send(672, 1'b1, 1'b0, 1'b0, 1'b1);
    resetN = 1'b0;
    tick(1);
    resetN = 1'b1;
    chk_reset_state("s6");
    w0 = wr_cnt;
    send(200, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s6_no_wr", 64'(wr_cnt), 64'(w0));
    chk("s6_banks", {60'd0, bankState}, 64'b0000);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ldpc_codeword_loader.md
LDPC_CODEWORD_LOADER -- requirements
Module: ldpc_codeword_loader

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge system clock; resetN in 1, synchronous active-low reset.
REQ-002 SHALL have ports: clkEn in 1, bit-rate enable; ldpcRun in 1, block enable; codeLength4096 in 1, k=4096 when high, else k=1024; codeRate in 2, LDPC_RATE_1_2/2_3/4_5 encodings from the address map.
REQ-003 SHALL have framer-side ports: dataBitIn in 1, hard bit; codewordEn in 1, payload window from framer; ldpcReady out 1, a codeword can be accepted.
REQ-004 SHALL have buffer write ports: wrEn out 1; wrAddr out 8, {bank, word[6:0]}; wrData out 64, first received bit in bit 63.
REQ-005 SHALL have decoder handshake ports: cwValid out 1; cwBank out 1; cwWords out 8, codeword length in words; cwTake in 1, one-cycle accept; decDone in 1, one-cycle completion; doneBank in 1.
REQ-006 SHALL have status ports: overflowCount out 8, saturating; abortCount out 8, saturating; bankState out 4, {bank1[1:0], bank0[1:0]}.

Function
REQ-007 SHALL set the words per codeword from codeRate and codeLength4096: 1/2 -> 32/128, 2/3 -> 24/96, 4/5 -> 20/80, other -> 32/128 (k=1024/k=4096); codeword length latched at codeword start.
REQ-008 SHALL track each of two banks as FREE(00), FULL(01) or BUSY(11); bank encoding 10 is illegal and SHALL recover to FREE.
REQ-009 SHALL run a fill FSM with states IDLE, FILL and DROP.
REQ-010 IDLE -> FILL on clkEn && codewordEn rising (previous sampled value 0) when a FREE bank exists; lowest-numbered FREE bank is selected; word index = 0, bit count = 0.
REQ-011 IDLE -> DROP on the same event when no bank is FREE; overflowCount increments once.
REQ-012 In FILL, each clkEn with codewordEn high SHALL shift dataBitIn into a 64-bit assembly register, MSB first.
REQ-013 On the 64th bit, wrEn SHALL pulse for exactly one clk on the next cycle, with wrAddr = {bank, word index} and wrData = assembled word; the word index then increments.
REQ-014 After the last word of the codeword is written, the bank SHALL become FULL in the same cycle as that wrEn, and the FSM returns to IDLE.
REQ-015 If codewordEn falls in FILL before the last word, the FSM SHALL return to IDLE, the bank remains FREE, and abortCount increments.
REQ-016 DROP -> IDLE when codewordEn falls; no writes occur in DROP.
REQ-017 cwValid SHALL be high whenever any bank is FULL; cwBank SHALL indicate the oldest FULL bank (completion order tracked); cwWords SHALL give that bank's latched length.
REQ-018 cwTake while cwValid SHALL move bank cwBank FULL -> BUSY; cwTake while cwValid is low SHALL be ignored.
REQ-019 decDone SHALL move bank doneBank BUSY -> FREE; decDone for a bank not in BUSY SHALL be ignored.
REQ-020 cwTake, decDone and a fill completion in the same cycle SHALL all take effect, including on different banks.
REQ-021 ldpcReady SHALL be registered and high when at least one FREE bank is not the bank being filled.
REQ-022 ldpcRun low SHALL act as reset for the FSM, the banks, wrEn and cwValid, but SHALL NOT clear the counters.
REQ-023 overflowCount and abortCount SHALL saturate at 255.

Reset
REQ-024 With resetN low at a clk edge, the block SHALL enter this state: FSM IDLE; both banks FREE; wrEn, cwValid, cwBank, wrAddr and wrData = 0; cwWords = 32; ldpcReady = 1; both counters = 0.
REQ-025 Reset asserted mid-FILL SHALL discard the partial codeword with no further wrEn.

Structure
REQ-026 Bank-state encodings, FSM state encodings and the words-per-codeword table SHALL live in a shared package/include, reused by ldpcFramer-family blocks.
REQ-027 A single sub-module, ldpc_word_packer (64-bit shift, bit count, word-ready strobe), SHALL be instantiated.

Verification
REQ-028 Scenario: rate 1/2, k=1024, 2048 payload bits with clkEn = 1 -> 32 wrEn pulses at addresses 0..31; cwValid = 1, cwBank = 0, cwWords = 32.
REQ-029 Scenario: two back-to-back rate 4/5 k=1024 codewords with no cwTake, then a third -> banks 0 and 1 FULL, ldpcReady = 0, overflowCount = 1, no wrEn during the third codeword.
REQ-030 Scenario: codewordEn dropped after 100 bits -> exactly one wrEn, abortCount = 1, bank 0 FREE, cwValid = 0.
REQ-031 Scenario: cwTake for bank 0 in the same cycle as decDone for bank 1 -> bankState = 4'b0011.
REQ-032 Scenario: resetN low at the middle of word 10 of a k=4096 rate 2/3 fill -> no further wrEn; all reset values per REQ-024 on the next cycle.
REQ-033 Scenario: pattern word 64'hFCB88938D8D76A4F sent MSB first -> wrData equals 64'hFCB88938D8D76A4F.
